// File: rtl/aes_mix_columns.sv
// Registered AES MixColumns (and optional InvMixColumns) over a 128-bit state.
// Ports: clk, rst (async, active-high), in_valid, state_in[0:127] (bit 0 = MSB of byte 0),
//        out_valid, state_out[0:127]; inv only when INV_MIX_COLUMNS_EN is defined.
module aes_mix_columns (
  input  logic         clk,
  input  logic         rst,
`ifdef INV_MIX_COLUMNS_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  input  logic [0:127] state_in,
  output logic         out_valid,
  output logic [0:127] state_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Column word layout: [31:24] = row 0 ... [7:0] = row 3.
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] d0, d1, d2, d3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    d0 = xtime(s0);
    d1 = xtime(s1);
    d2 = xtime(s2);
    d3 = xtime(s3);
    fwd_col[31:24] = d0 ^ (d1 ^ s1) ^ s2 ^ s3;
    fwd_col[23:16] = s0 ^ d1 ^ (d2 ^ s2) ^ s3;
    fwd_col[15:8]  = s0 ^ s1 ^ d2 ^ (d3 ^ s3);
    fwd_col[7:0]   = (d0 ^ s0) ^ s1 ^ s2 ^ d3;
  endfunction

`ifdef INV_MIX_COLUMNS_EN
  // 9 = 8+1, B = 8+2+1, D = 8+4+1, E = 8+4+2 from chained xtime.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    inv_col[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    inv_col[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    inv_col[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    inv_col[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
  endfunction
`endif

  logic [0:127] w_mix;
  logic         r_valid;
  logic [0:127] r_state;

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [31:0] w_col_in;
    logic [31:0] w_col_out;
    assign w_col_in = state_in[32*c +: 32];
`ifdef INV_MIX_COLUMNS_EN
    assign w_col_out = inv ? inv_col(w_col_in) : fwd_col(w_col_in);
`else
    assign w_col_out = fwd_col(w_col_in);
`endif
    assign w_mix[32*c +: 32] = w_col_out;
  end

  // Data register only loads on valid so idle-cycle X never reaches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_state <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_state <= w_mix;
      end
    end
  end

  assign out_valid = r_valid;
  assign state_out = r_state;

endmodule

// File: tb/tb_aes_mix_columns.sv
// Self-checking bench for aes_mix_columns: directed steps with a scoreboard queue.
// Expected states come from FIPS constants or a generic GF(2^8) multiply model.
module tb_aes_mix_columns;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inv = 1'b0;
  logic         in_valid = 1'b0;
  logic [0:127] state_in = '0;
  logic         out_valid;
  logic [0:127] state_out;

  aes_mix_columns dut (
    .clk       (clk),
    .rst       (rst),
`ifdef INV_MIX_COLUMNS_EN
    .inv       (inv),
`endif
    .in_valid  (in_valid),
    .state_in  (state_in),
    .out_valid (out_valid),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] q[$];
  logic [127:0] held = '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic do_inv);
    logic [7:0]   m [4][4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (do_inv) m = '{'{8'h0E, 8'h0B, 8'h0D, 8'h09}, '{8'h09, 8'h0E, 8'h0B, 8'h0D},
                      '{8'h0D, 8'h09, 8'h0E, 8'h0B}, '{8'h0B, 8'h0D, 8'h09, 8'h0E}};
    else        m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                      '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(m[row][k], s[127 - 8*(4*c+k) -: 8]);
        r[127 - 8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [127:0] d,
                      input logic [127:0] e);
    logic [127:0] exp;
    @(negedge clk);
    in_valid = v;
    state_in = d;
    if (v) q.push_back(e);
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, {127'd0, out_valid}, {127'd0, v});
    if (v) begin
      if (q.size() == 0) begin
        chk({tag, "_qempty"}, 128'd1, 128'd0);
      end else begin
        exp = q.pop_front();
        chk({tag, "_data"}, state_out, exp);
        held = exp;
      end
    end else begin
      chk({tag, "_hold"}, state_out, held);
    end
  endtask

  logic [127:0] rnd;
  logic [127:0] fwd;

  initial begin
    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_vld", {127'd0, out_valid}, 128'd0);
    chk("rst_async_data", state_out, 128'd0);
    in_valid = 1'b1;
    state_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_vld", {127'd0, out_valid}, 128'd0);
    chk("rst_hold_data", state_out, 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    held = '0;

    step("fips", 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5,
         128'h046681e5e0cb199a48f8d37a2806264c);
    step("b2b0", 1'b1, 128'h84e1dd691a41d76f792d389783fbac70,
         128'h9f487f794f955f662afc86abd7f1ab29);
    step("b2b1", 1'b1, 128'h6353e08c0960e104cd70b751bacad0e7,
         128'h5f72641557f5bc92f7be3b291db9f91a);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    step("idle_rand", 1'b0, rnd, '0);
    step("idle_x", 1'b0, 'x, '0);
    step("ones", 1'b1, {16{8'h01}}, {16{8'h01}});
    step("zero", 1'b1, '0, '0);
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step("rand", 1'b1, rnd, model(rnd, 1'b0));
    end
    step("idle_end", 1'b0, '0, '0);

    // reset while a result is in flight
    @(negedge clk);
    in_valid = 1'b1;
    state_in = 128'h84e1dd691a41d76f792d389783fbac70;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_vld", {127'd0, out_valid}, 128'd0);
    chk("midrst_data", state_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    held = '0;
    step("after_rst", 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5,
         128'h046681e5e0cb199a48f8d37a2806264c);

`ifdef INV_MIX_COLUMNS_EN
    @(negedge clk);
    inv = 1'b1;
    step("inv_fips", 1'b1, 128'h046681e5e0cb199a48f8d37a2806264c,
         128'hd4bf5d30e0b452aeb84111f11e2798e5);
    for (int i = 0; i < 3; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      fwd = model(rnd, 1'b0);
      @(negedge clk);
      inv = 1'b0;
      step("rt_fwd", 1'b1, rnd, fwd);
      @(negedge clk);
      inv = 1'b1;
      step("rt_inv", 1'b1, state_out, rnd);
    end
    @(negedge clk);
    inv = 1'b0;
`endif

    step("final_idle", 1'b0, '0, '0);
    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
